// File: rtl/elev_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elev_pkg
// Brief    : Shared state encodings, countdown width and direction constants
//            for the elevator scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package elev_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR_OPEN = 2'd3
  } elev_state_t;

  localparam int unsigned CW = 4;

  localparam logic c_dir_up   = 1'b1;
  localparam logic c_dir_down = 1'b0;

endpackage
`default_nettype wire

// File: rtl/elev_request_bank.sv
`default_nettype none
// ============================================================================
// Module   : elev_request_bank
// Brief    : Latches car / hall calls into pending vectors, clears the ones
//            served at the current floor, and reports where requests remain
//            relative to that floor.
// Revision : 1.0 - initial release
// ============================================================================
module elev_request_bank
  import elev_pkg::*;
#(
  parameter int N_FLOORS = 8,
  parameter int FW       = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] car_call,
  input  logic [N_FLOORS-1:0] up_call,
  input  logic [N_FLOORS-1:0] down_call,
  input  logic [FW-1:0]       floor,
  input  logic                dir,
  input  logic                door_open,
  input  logic                serve,
  output logic [N_FLOORS-1:0] pend_car,
  output logic [N_FLOORS-1:0] pend_up,
  output logic [N_FLOORS-1:0] pend_down,
  output logic                any_above,
  output logic                any_below,
  output logic                at_floor,
  output logic                call_here
);

  // No up button on the top floor, no down button on the bottom floor.
  localparam logic [N_FLOORS-1:0] c_up_mask = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] c_dn_mask = {{(N_FLOORS-1){1'b1}}, 1'b0};

  logic [N_FLOORS-1:0] r_car, r_up, r_dn;
  logic [N_FLOORS-1:0] w_here, w_above, w_below;
  logic [N_FLOORS-1:0] w_up_in, w_dn_in, w_req, w_block;
  logic [N_FLOORS-1:0] w_clr_car, w_clr_up, w_clr_dn;
  logic                w_beyond;

  // Position masks of every floor relative to the current one.
  for (genvar i = 0; i < N_FLOORS; i++) begin : g_pos
    assign w_here[i]  = (FW'(i) == floor);
    assign w_above[i] = (FW'(i) >  floor);
    assign w_below[i] = (FW'(i) <  floor);
  end

  assign w_up_in   = up_call   & c_up_mask;
  assign w_dn_in   = down_call & c_dn_mask;
  assign w_req     = r_car | r_up | r_dn;

  assign any_above = |(w_req & w_above);
  assign any_below = |(w_req & w_below);
  assign at_floor  = |(w_req & w_here);
  assign call_here = |((car_call | w_up_in | w_dn_in) & w_here);

  // With the door open, presses at this floor are absorbed by the door timer.
  assign w_block   = door_open ? w_here : '0;

  // The opposite hall call is also answered when nothing lies further on.
  assign w_beyond  = (dir == c_dir_up) ? any_above : any_below;
  assign w_clr_car = serve ? w_here : '0;
  assign w_clr_up  = (serve && ((dir == c_dir_up)   || !w_beyond)) ? w_here : '0;
  assign w_clr_dn  = (serve && ((dir == c_dir_down) || !w_beyond)) ? w_here : '0;

  // Latch new calls, then drop the ones served on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_car <= '0;
      r_up  <= '0;
      r_dn  <= '0;
    end else begin
      r_car <= (r_car | (car_call & ~w_block)) & ~w_clr_car;
      r_up  <= (r_up  | (w_up_in  & ~w_block)) & ~w_clr_up;
      r_dn  <= (r_dn  | (w_dn_in  & ~w_block)) & ~w_clr_dn;
    end
  end

  assign pend_car  = r_car;
  assign pend_up   = r_up;
  assign pend_down = r_dn;

endmodule
`default_nettype wire

// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : elevator_scheduler
// Brief    : Single-car elevator controller: direction-preserving scheduling,
//            tick-based travel and door timing, latched call requests.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_scheduler
  import elev_pkg::*;
#(
  parameter int N_FLOORS   = 8,
  parameter int MOVE_TICKS = 2,
  parameter int DOOR_TICKS = 3,
  localparam int FW        = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [N_FLOORS-1:0] car_call,
  input  logic [N_FLOORS-1:0] up_call,
  input  logic [N_FLOORS-1:0] down_call,
  input  logic                door_open_btn,
  input  logic                door_close_btn,
  output logic [FW-1:0]       floor,
  output logic [1:0]          state,
  output logic [CW-1:0]       countdown,
  output logic [N_FLOORS-1:0] pend_car,
  output logic [N_FLOORS-1:0] pend_up,
  output logic [N_FLOORS-1:0] pend_down
);

  localparam logic [CW-1:0] c_move_cnt = CW'(MOVE_TICKS);
  localparam logic [CW-1:0] c_door_cnt = CW'(DOOR_TICKS);

  elev_state_t   r_state, w_state_nxt;
  logic [FW-1:0] r_floor, w_floor_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_dir, w_dir_nxt;
  logic          w_serve;
  logic          w_any_above, w_any_below, w_at_floor, w_call_here;
  logic          w_going_up, w_at_end, w_same_hall, w_beyond, w_stop;

  elev_request_bank #(
    .N_FLOORS (N_FLOORS),
    .FW       (FW)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .car_call  (car_call),
    .up_call   (up_call),
    .down_call (down_call),
    .floor     (r_floor),
    .dir       (r_dir),
    .door_open (r_state == ST_DOOR_OPEN),
    .serve     (w_serve),
    .pend_car  (pend_car),
    .pend_up   (pend_up),
    .pend_down (pend_down),
    .any_above (w_any_above),
    .any_below (w_any_below),
    .at_floor  (w_at_floor),
    .call_here (w_call_here)
  );

  // Stop decision at the floor just reached; end floors always stop.
  assign w_going_up  = (r_state == ST_MOVE_UP);
  assign w_at_end    = w_going_up ? (r_floor == FW'(N_FLOORS - 1)) : (r_floor == '0);
  assign w_same_hall = w_going_up ? pend_up[r_floor] : pend_down[r_floor];
  assign w_beyond    = w_going_up ? w_any_above : w_any_below;
  assign w_stop      = pend_car[r_floor] | w_same_hall | ~w_beyond | w_at_end;

  // State, floor, countdown and direction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_floor <= '0;
      r_cnt   <= '0;
      r_dir   <= c_dir_up;
    end else begin
      r_state <= w_state_nxt;
      r_floor <= w_floor_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  // Next-state logic; a MOVE cycle with countdown 0 is the arrival decision.
  always_comb begin
    w_state_nxt = r_state;
    w_floor_nxt = r_floor;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_serve     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_at_floor) begin
          w_state_nxt = ST_DOOR_OPEN;
          w_cnt_nxt   = c_door_cnt;
          w_serve     = 1'b1;
        end else if (w_any_above || w_any_below) begin
          w_dir_nxt   = (w_any_above && w_any_below) ? r_dir :
                        (w_any_above ? c_dir_up : c_dir_down);
          w_state_nxt = (w_dir_nxt == c_dir_up) ? ST_MOVE_UP : ST_MOVE_DOWN;
          w_cnt_nxt   = c_move_cnt;
        end
      end
      ST_MOVE_UP, ST_MOVE_DOWN: begin
        if (r_cnt == '0) begin
          if (w_stop) begin
            w_state_nxt = ST_DOOR_OPEN;
            w_cnt_nxt   = c_door_cnt;
            w_serve     = 1'b1;
          end else begin
            w_cnt_nxt   = c_move_cnt;
          end
        end else if (tick) begin
          w_cnt_nxt = r_cnt - 1'b1;
          if ((r_cnt == CW'(1)) && !w_at_end) begin
            w_floor_nxt = w_going_up ? (r_floor + 1'b1) : (r_floor - 1'b1);
          end
        end
      end
      ST_DOOR_OPEN: begin
        // A press or call here holds the door even on its last cycle, so the
        // call is never dropped between the blocked latch and leaving.
        if (door_open_btn || w_call_here) begin
          w_cnt_nxt   = c_door_cnt;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else if (door_close_btn) begin
          w_cnt_nxt   = '0;
        end else if (tick) begin
          w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign floor     = r_floor;
  assign state     = r_state;
  assign countdown = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_scheduler
// Brief    : Scoreboard bench for elevator_scheduler with a behavioural
//            reference model, directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_scheduler;

  localparam int N  = 8;
  localparam int MT = 2;
  localparam int DT = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         tick = 1'b0;
  logic [N-1:0] car_call = '0, up_call = '0, down_call = '0;
  logic         door_open_btn = 1'b0, door_close_btn = 1'b0;
  logic [2:0]   floor;
  logic [1:0]   state;
  logic [3:0]   countdown;
  logic [N-1:0] pend_car, pend_up, pend_down;

  elevator_scheduler #(.N_FLOORS(N), .MOVE_TICKS(MT), .DOOR_TICKS(DT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tick           (tick),
    .car_call       (car_call),
    .up_call        (up_call),
    .down_call      (down_call),
    .door_open_btn  (door_open_btn),
    .door_close_btn (door_close_btn),
    .floor          (floor),
    .state          (state),
    .countdown      (countdown),
    .pend_car       (pend_car),
    .pend_up        (pend_up),
    .pend_down      (pend_down)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   floor;
    logic [1:0]   state;
    logic [3:0]   cnt;
    logic [N-1:0] car;
    logic [N-1:0] up;
    logic [N-1:0] dn;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0;
  int    failures = 0;

  // Reference model: 0 idle, 1 up, 2 down, 3 door.
  int       m_floor, m_state, m_cnt;
  bit       m_dir_up;
  bit [N-1:0] m_car, m_up, m_dn;

  task automatic model_reset();
    m_floor = 0; m_state = 0; m_cnt = 0; m_dir_up = 1'b1;
    m_car = '0; m_up = '0; m_dn = '0;
  endtask

  task automatic model_step(input bit [N-1:0] c, input bit [N-1:0] u_raw,
                            input bit [N-1:0] d_raw, input bit t,
                            input bit op, input bit cl);
    bit [N-1:0] u, d, req, nc, nu, nd;
    int f, ns, nf, ncnt;
    bit above, below, ndir, serve, up_move, stop, beyond;
    snap_t s;
    u = u_raw; u[N-1] = 1'b0;
    d = d_raw; d[0] = 1'b0;
    f = m_floor; ns = m_state; nf = m_floor; ncnt = m_cnt; ndir = m_dir_up;
    serve = 1'b0; above = 1'b0; below = 1'b0;
    req = m_car | m_up | m_dn;
    for (int i = 0; i < N; i++) begin
      if (req[i] && i > f) above = 1'b1;
      if (req[i] && i < f) below = 1'b1;
    end
    case (m_state)
      0: begin
        if (req[f]) begin
          ns = 3; ncnt = DT; serve = 1'b1;
        end else if (above || below) begin
          ndir = (above && below) ? m_dir_up : above;
          ns = ndir ? 1 : 2; ncnt = MT;
        end
      end
      1, 2: begin
        up_move = (m_state == 1);
        if (m_cnt == 0) begin
          stop = m_car[f] || (up_move ? m_up[f] : m_dn[f]) ||
                 !(up_move ? above : below) || (up_move ? (f == N-1) : (f == 0));
          if (stop) begin ns = 3; ncnt = DT; serve = 1'b1; end
          else ncnt = MT;
        end else if (t) begin
          ncnt = m_cnt - 1;
          if (ncnt == 0) nf = up_move ? f + 1 : f - 1;
        end
      end
      default: begin
        if (op || c[f] || u[f] || d[f]) ncnt = DT;
        else if (m_cnt == 0) ns = 0;
        else if (cl) ncnt = 0;
        else if (t) ncnt = m_cnt - 1;
      end
    endcase
    nc = m_car; nu = m_up; nd = m_dn;
    for (int i = 0; i < N; i++) begin
      if (!(m_state == 3 && i == f)) begin
        nc[i] = nc[i] | c[i];
        nu[i] = nu[i] | u[i];
        nd[i] = nd[i] | d[i];
      end
    end
    if (serve) begin
      beyond = m_dir_up ? above : below;
      nc[f] = 1'b0;
      if (m_dir_up || !beyond) nu[f] = 1'b0;
      if (!m_dir_up || !beyond) nd[f] = 1'b0;
    end
    m_floor = nf; m_state = ns; m_cnt = ncnt; m_dir_up = ndir;
    m_car = nc; m_up = nu; m_dn = nd;
    s.floor = 3'(nf); s.state = 2'(ns); s.cnt = 4'(ncnt);
    s.car = nc; s.up = nu; s.dn = nd;
    exp_q.push_back(s);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs (caller is at a negedge) and predict the edge.
  task automatic apply(input logic [N-1:0] c, input logic [N-1:0] u,
                       input logic [N-1:0] d, input logic t,
                       input logic op, input logic cl);
    car_call = c; up_call = u; down_call = d; tick = t;
    door_open_btn = op; door_close_btn = cl;
    model_step(c, u, d, t, op, cl);
  endtask

  task automatic cyc(input logic [N-1:0] c, input logic [N-1:0] u,
                     input logic [N-1:0] d, input logic t,
                     input logic op, input logic cl);
    @(negedge clk);
    apply(c, u, d, t, op, cl);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic run_until_state(input int target, input int budget);
    int k;
    k = 0;
    while (m_state != target && k < budget) begin
      cyc('0, '0, '0, (k % 2) == 0, 1'b0, 1'b0);
      k++;
    end
    checks++;
    if (m_state != target) begin
      failures++;
      $display("FAIL reach_state actual=%0d expected=%0d after %0d cycles", m_state, target, k);
    end
  endtask

  // Assert reset between edges and check it acts without a clock.
  task automatic async_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_floor", floor, 0);
    chk("rst_state", state, 0);
    chk("rst_countdown", countdown, 0);
    chk("rst_pend", {pend_car, pend_up, pend_down}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply('0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare every predicted post-edge snapshot with the DUT.
  initial begin
    snap_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.floor = floor; a.state = state; a.cnt = countdown;
        a.car = pend_car; a.up = pend_up; a.dn = pend_down;
        checks++;
        if (a != e) begin
          failures++;
          $display("FAIL scoreboard t=%0t actual floor=%0d state=%0d cnt=%0d car=%h up=%h dn=%h expected floor=%0d state=%0d cnt=%0d car=%h up=%h dn=%h",
                   $time, a.floor, a.state, a.cnt, a.car, a.up, a.dn,
                   e.floor, e.state, e.cnt, e.car, e.up, e.dn);
        end
      end
    end
  end

  initial begin
    int k;
    logic [N-1:0] rc, ru, rd;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("init_floor", floor, 0);
    chk("init_state", state, 0);
    chk("init_countdown", countdown, 0);
    chk("init_pend", {pend_car, pend_up, pend_down}, 0);

    // Release with a car call already present: it latches on the first edge.
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'h08, '0, '0, 1'b0, 1'b0, 1'b0);
    cyc('0, '0, '0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("start_move_state", state, 1);
    chk("start_move_cnt", countdown, MT);
    run_until_state(3, 60);
    settle();
    chk("arrive3_floor", floor, 3);
    chk("arrive3_state", state, 3);
    chk("arrive3_pend_car", pend_car, 0);
    chk("arrive3_cnt", countdown, DT);

    // Door buttons.
    cyc('0, '0, '0, 1'b1, 1'b0, 1'b0);
    cyc('0, '0, '0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("door_cnt1", countdown, 1);
    cyc('0, '0, '0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("door_open_reload", countdown, DT);
    cyc('0, '0, '0, 1'b1, 1'b1, 1'b1);
    settle();
    chk("door_both_reload", countdown, DT);
    cyc('0, '0, '0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("door_close_cnt", countdown, 0);
    cyc('0, '0, '0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("door_close_idle", state, 0);

    // Hall calls ahead: up at 5 served first, down at 4 on the way back.
    cyc('0, 8'h20, 8'h10, 1'b0, 1'b0, 1'b0);
    run_until_state(3, 80);
    settle();
    chk("stop5_floor", floor, 5);
    chk("stop5_pend_down4", pend_down[4], 1);
    chk("stop5_pend_up5", pend_up[5], 0);
    run_until_state(0, 40);
    run_until_state(3, 80);
    settle();
    chk("stop4_floor", floor, 4);
    chk("stop4_pend_down", pend_down, 0);

    // Top floor: car and (ignored) up call at floor 7.
    run_until_state(0, 40);
    cyc(8'h80, '0, '0, 1'b0, 1'b0, 1'b0);
    run_until_state(3, 100);
    run_until_state(0, 40);
    settle();
    chk("top_idle_floor", floor, 7);
    for (int i = 0; i < 3; i++) cyc(8'h80, 8'h80, '0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("top_door_state", state, 3);
    chk("top_door_floor", floor, 7);
    chk("top_pend_up", pend_up, 0);
    chk("top_pend_car", pend_car, 0);
    chk("top_door_cnt", countdown, DT);
    cyc('0, '0, '0, 1'b0, 1'b0, 1'b0);
    run_until_state(0, 40);

    // Reset while moving with requests pending.
    cyc(8'h04, 8'h02, '0, 1'b0, 1'b0, 1'b0);
    k = 0;
    while (!(m_state == 2 && m_cnt == 1) && k < 20) begin
      cyc('0, '0, '0, 1'b1, 1'b0, 1'b0);
      k++;
    end
    chk("midmove_reached", m_cnt, 1);
    async_reset();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(399) == 0) begin
        async_reset();
      end else begin
        rc = '0; ru = '0; rd = '0;
        if ($urandom_range(3) == 0) begin
          rc = N'($urandom & $urandom & $urandom);
          ru = N'($urandom & $urandom & $urandom & $urandom);
          rd = N'($urandom & $urandom & $urandom & $urandom);
        end
        cyc(rc, ru, rd, $urandom_range(2) == 0,
            $urandom_range(15) == 0, $urandom_range(11) == 0);
      end
    end

    @(negedge clk);
    apply('0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
